axis_upsize_rtl: RTL and testbench

AXI4-Stream width upconverter that packs RATIO consecutive narrow beats into one wide beat. It sits directly upstream of the stream register-slice array. It turns a narrow producer stream into the wide datapath that the slice array pipelines across the die. A tlast on the narrow side flushes a partially filled wide beat, and unfilled lanes carry tkeep = 0.

---
 rtl/axis_upsize_rtl.sv | 130 +++++++++++++
 tb/tb_axis_upsize_rtl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_upsize_rtl.sv
// axis_upsize_rtl
// AXI4-Stream width upconverter. It packs RATIO consecutive narrow beats into
// one wide beat. A narrow tlast closes the current wide beat early. Lanes that
// were not filled carry data 0 and keep 0.
//
// Ports
//   aclk, aresetn             clock; asynchronous active-low reset
//   s_axis_t{data,keep,valid,last}, s_axis_tready
//                             narrow slave side, S_DATA_BITS wide
//   m_axis_t{data,keep,valid,last}, m_axis_tready
//                             wide master side, S_DATA_BITS*RATIO wide;
//                             lane k = bits [k*S_DATA_BITS +: S_DATA_BITS]
module axis_upsize_rtl #(
  parameter  int S_DATA_BITS = 32,
  parameter  int RATIO       = 4,
  localparam int M_DATA_BITS = S_DATA_BITS * RATIO
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [S_DATA_BITS-1:0]   s_axis_tdata,
  input  logic [S_DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [M_DATA_BITS-1:0]   m_axis_tdata,
  output logic [M_DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast
);

  localparam int S_KEEP_BITS = S_DATA_BITS / 8;
  localparam int M_KEEP_BITS = M_DATA_BITS / 8;
  localparam int IDX_W       = $clog2(RATIO);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  // The assembly buffer holds lanes 0..RATIO-2 only. The last lane always
  // completes the word, so it goes straight from the input into the output
  // register.
  logic [IDX_W-1:0]                          idx_q, idx_d;
  logic [RATIO-2:0][S_DATA_BITS-1:0]         buf_data_q, buf_data_d;
  logic [RATIO-2:0][S_KEEP_BITS-1:0]         buf_keep_q, buf_keep_d;
  logic [M_DATA_BITS-1:0]                    out_data_q, out_data_d;
  logic [M_KEEP_BITS-1:0]                    out_keep_q, out_keep_d;
  logic                                      out_last_q, out_last_d;
  logic                                      out_valid_q, out_valid_d;

  logic s_ready;
  logic accept;
  logic completing;

  // The output register is the only storage on the wide side. It can accept
  // a new word when it is empty or is draining this cycle. Gating with aresetn
  // holds ready low while reset is asserted.
  assign s_ready    = aresetn && (!out_valid_q || m_axis_tready);
  assign accept     = s_axis_tvalid && s_ready;
  assign completing = accept && ((idx_q == IDX_LAST) || s_axis_tlast);

  always_comb begin
    idx_d       = idx_q;
    buf_data_d  = buf_data_q;
    buf_keep_d  = buf_keep_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && m_axis_tready) begin
      out_valid_d = 1'b0;
    end

    if (completing) begin
      // Lanes below idx come from the buffer. Lane idx is the current beat.
      // Lanes above idx stay zero.
      out_data_d = '0;
      out_keep_d = '0;
      for (int k = 0; k < RATIO - 1; k++) begin
        if (IDX_W'(k) < idx_q) begin
          out_data_d[k*S_DATA_BITS +: S_DATA_BITS] = buf_data_q[k];
          out_keep_d[k*S_KEEP_BITS +: S_KEEP_BITS] = buf_keep_q[k];
        end
      end
      for (int k = 0; k < RATIO; k++) begin
        if (IDX_W'(k) == idx_q) begin
          out_data_d[k*S_DATA_BITS +: S_DATA_BITS] = s_axis_tdata;
          out_keep_d[k*S_KEEP_BITS +: S_KEEP_BITS] = s_axis_tkeep;
        end
      end
      out_last_d  = s_axis_tlast;
      out_valid_d = 1'b1;
      idx_d       = '0;
      buf_keep_d  = '0;
    end else if (accept) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (IDX_W'(k) == idx_q) begin
          buf_data_d[k] = s_axis_tdata;
          buf_keep_d[k] = s_axis_tkeep;
        end
      end
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx_q       <= '0;
      buf_data_q  <= '0;
      buf_keep_q  <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      buf_data_q  <= buf_data_d;
      buf_keep_q  <= buf_keep_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;

endmodule

// File: tb/tb_axis_upsize_rtl.sv
module tb_axis_upsize_rtl;

  localparam int S = 32;
  localparam int R = 4;
  localparam int M = S * R;

  logic           aclk;
  logic           aresetn;
  logic [S-1:0]   s_tdata;
  logic [S/8-1:0] s_tkeep;
  logic           s_tvalid;
  logic           s_tready;
  logic           s_tlast;
  logic [M-1:0]   m_tdata;
  logic [M/8-1:0] m_tkeep;
  logic           m_tvalid;
  logic           m_tready;
  logic           m_tlast;

  axis_upsize_rtl #(.S_DATA_BITS(S), .RATIO(R)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [M-1:0]   data;
    logic [M/8-1:0] keep;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   nbeats  = 0;
  int   cyc     = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every wide handshake pops one expected beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && m_tvalid && m_tready) begin
        nbeats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %h keep %h, expected no beat", m_tdata, m_tkeep);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", m_tdata, e.data);
          chk("sb_keep", M'(m_tkeep), M'(e.keep));
          chk("sb_last", M'(m_tlast), M'(e.last));
        end
      end
    end
  end

  function automatic exp_t mk(input logic [M-1:0] d, input logic [M/8-1:0] k, input logic l);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    return e;
  endfunction

  // Called just after a rising edge. Returns just after the accepting edge and
  // leaves tvalid asserted so back-to-back calls stream without bubbles.
  task automatic send(input logic [S-1:0] d, input logic [S/8-1:0] k, input logic l);
    bit done = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge aclk);
      if (s_tready) begin
        @(posedge aclk);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake for %h, expected one within 100 cycles", d);
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic reset_pulse();
    aresetn = 1'b0;
    #1;
    chk("rst_m_tvalid", M'(m_tvalid), '0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_m_tkeep", M'(m_tkeep), '0);
    chk("rst_m_tlast", M'(m_tlast), '0);
    chk("rst_s_tready", M'(s_tready), '0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    int c0;
    int n0;
    logic [M-1:0]   wd;
    logic [M/8-1:0] wk;
    logic [3:0]     k4;
    logic [S-1:0]   d;

    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset state
    cycles(2);
    chk("init_m_tvalid", M'(m_tvalid), '0);
    chk("init_m_tdata", m_tdata, '0);
    chk("init_m_tkeep", M'(m_tkeep), '0);
    chk("init_m_tlast", M'(m_tlast), '0);
    chk("init_s_tready", M'(s_tready), '0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("release_s_tready", M'(s_tready), 1);
    @(posedge aclk);
    #1;

    // Full word
    exp_q.push_back(mk(128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1));
    send(32'h11111111, 4'hF, 1'b0);
    send(32'h22222222, 4'hF, 1'b0);
    send(32'h33333333, 4'hF, 1'b0);
    send(32'h44444444, 4'hF, 1'b1);
    idle();
    chk("latency_m_tvalid", M'(m_tvalid), 1);
    cycles(1);
    chk("drained_m_tvalid", M'(m_tvalid), 0);

    // Partial flush, next beat in lane 0 with a partial keep
    exp_q.push_back(mk(128'h0, 16'h00FF, 1'b1));
    exp_q[$].data = 128'h00000000_00000000_0000000B_0000000A;
    send(32'hA, 4'hF, 1'b0);
    send(32'hB, 4'hF, 1'b1);
    exp_q.push_back(mk(128'h00000000_00000000_00000000_0000000C, 16'h0003, 1'b1));
    send(32'hC, 4'h3, 1'b1);
    // Single-beat packet
    exp_q.push_back(mk(128'h00000000_00000000_00000000_00000005, 16'h000F, 1'b1));
    send(32'h5, 4'hF, 1'b1);
    // All-zero narrow keep still occupies its lane
    exp_q.push_back(mk(128'h00000000_00000000_00000002_00000001, 16'h00F0, 1'b1));
    send(32'h1, 4'h0, 1'b0);
    send(32'h2, 4'hF, 1'b1);
    // Full word without tlast gives last = 0
    exp_q.push_back(mk(128'hD4_000000D3_000000D2_000000D1, 16'hFFFF, 1'b0));
    send(32'hD1, 4'hF, 1'b0);
    send(32'hD2, 4'hF, 1'b0);
    send(32'hD3, 4'hF, 1'b0);
    send(32'hD4, 4'hF, 1'b0);
    idle();
    cycles(2);

    // Backpressure
    m_tready = 1'b0;
    exp_q.push_back(mk(128'h00000084_00000083_00000082_00000081, 16'hFFFF, 1'b1));
    send(32'h81, 4'hF, 1'b0);
    send(32'h82, 4'hF, 1'b0);
    send(32'h83, 4'hF, 1'b0);
    send(32'h84, 4'hF, 1'b1);
    s_tdata  = 32'h91;
    s_tkeep  = 4'hF;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("bp_s_tready", M'(s_tready), 0);
      chk("bp_m_tvalid", M'(m_tvalid), 1);
      chk("bp_m_tdata", m_tdata, 128'h00000084_00000083_00000082_00000081);
      chk("bp_m_tkeep", M'(m_tkeep), M'(16'hFFFF));
    end
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    exp_q.push_back(mk(128'h00000094_00000093_00000092_00000091, 16'hFFFF, 1'b1));
    send(32'h91, 4'hF, 1'b0);
    send(32'h92, 4'hF, 1'b0);
    send(32'h93, 4'hF, 1'b0);
    send(32'h94, 4'hF, 1'b1);
    idle();
    cycles(2);

    // Streaming, 64 beats with random keep
    n0 = nbeats;
    c0 = cyc;
    wd = '0;
    wk = '0;
    for (int i = 0; i < 64; i++) begin
      d  = 32'hC000_0000 + 32'(i);
      k4 = 4'($urandom_range(0, 15));
      if (i % 4 == 0) begin
        wd = '0;
        wk = '0;
      end
      wd[(i%4)*32 +: 32] = d;
      wk[(i%4)*4 +: 4]   = k4;
      if (i % 4 == 3) exp_q.push_back(mk(wd, wk, 1'b1));
      send(d, k4, i % 4 == 3);
    end
    chk("stream_cycles", M'(cyc - c0), 64);
    idle();
    cycles(2);
    chk("stream_beats", M'(nbeats - n0), 16);

    // Reset with a pending wide beat: it must vanish
    m_tready = 1'b0;
    send(32'hE1, 4'hF, 1'b0);
    send(32'hE2, 4'hF, 1'b0);
    send(32'hE3, 4'hF, 1'b0);
    send(32'hE4, 4'hF, 1'b1);
    idle();
    chk("pending_m_tvalid", M'(m_tvalid), 1);
    reset_pulse();
    m_tready = 1'b1;

    // Reset mid-packet: the partial buffer must vanish
    n0 = nbeats;
    send(32'hB1, 4'hF, 1'b0);
    send(32'hB2, 4'hF, 1'b0);
    idle();
    reset_pulse();
    exp_q.push_back(mk(128'h000000F4_000000F3_000000F2_000000F1, 16'hFFFF, 1'b1));
    send(32'hF1, 4'hF, 1'b0);
    send(32'hF2, 4'hF, 1'b0);
    send(32'hF3, 4'hF, 1'b0);
    send(32'hF4, 4'hF, 1'b1);
    idle();
    cycles(3);
    chk("post_reset_beats", M'(nbeats - n0), 1);
    chk("sb_empty", M'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
